uart_rx_fsm: RTL and testbench
==============================

# uart_rx_fsm

Frame sequencer for the UART receiver. Detects the start-bit falling edge on `RX_IN` and runs the per-bit oversampling counters. Steps through start, data, optional parity and stop phases, enabling the sampler, deserializer and the start/parity/stop checkers in turn. Reads their error flags at the end of each bit, aborts bad frames and pulses `data_valid` for each good frame.

## Interface
- `DATA_BITS`, 8: data bits per frame.
- `clk` input 1: receiver clock at Prescale × baud.
- `rst` input 1: asynchronous, active-low reset.
- `RX_IN` input 1: serial line (idle high).
- `PAR_EN` input 1: parity bit present.
- `Prescale` input 6: oversampling ratio. Supported values are 8, 16 and 32.
- `strt_glitch` input 1: start checker result, valid from edge `Prescale/2+3` of the start bit.
- `par_error` input 1: parity checker result, valid from edge `Prescale/2+3` of the parity bit.
- `stop_error` input 1: stop checker result, valid from edge `Prescale/2+3` of the stop bit.
- `edge_count` output 5: oversample index within the current bit.
- `bit_count` output 4: bit index within the frame; start bit is 0.
- `dat_samp_en` output 1: sampler enable.
- `strt_check_en` output 1: start checker enable.
- `deser_en` output 1: deserializer enable.
- `par_check_en` output 1: parity checker enable.
- `stop_check_en` output 1: stop checker enable.
- `data_valid` output 1: one-cycle pulse marking a good frame.

## Operation
- States: `IDLE`, `START`, `DATA`, `PARITY`, `STOP`, `DONE`.
- "Bit end" means `edge_count == Prescale_q-1`.
- `IDLE`:
  - Counters are held at 0.
  - When `RX_IN==0`: go to `START`, and latch `PAR_EN` and `Prescale` into `par_en_q` / `Prescale_q` for the whole frame.
- Counting in all states other than `IDLE` and `DONE`:
  - `edge_count` increments every cycle.
  - At bit end, `edge_count` wraps to 0 and `bit_count` increments.
- `START` at bit end: go to `IDLE` if `strt_glitch`, else `DATA`.
- `DATA` at bit end with `bit_count==DATA_BITS`: go to `PARITY` if `par_en_q`, else `STOP`.
- `PARITY` at bit end: go to `IDLE` if `par_error`, else `STOP`.
- `STOP` at bit end: go to `IDLE` if `stop_error`, else `DONE`.
- `DONE`:
  - Lasts exactly one cycle with `data_valid=1`.
  - Next state is `START` if `RX_IN==0` (back-to-back frame; the line is already low), else `IDLE`.
  - Counters restart at 0.
- Enables are pure decodes of the current state:
  - `dat_samp_en` is high in `START`, `DATA`, `PARITY` and `STOP`.
  - `strt_check_en` is high only in `START`, `deser_en` only in `DATA`, `par_check_en` only in `PARITY`, `stop_check_en` only in `STOP`.
- Any abort to `IDLE` clears both counters on the transition cycle. No `data_valid` is produced for an aborted frame.
- Unsupported `Prescale` values (anything other than 8, 16 or 32) are latched as 8.

## Timing
- Reset values:
  - State is `IDLE`; `edge_count`, `bit_count` and all enables are 0; `data_valid` is 0.
  - Reset asserted mid-frame returns to `IDLE` immediately (asynchronous); no `data_valid` is generated for that frame.
- Entry latency: `RX_IN` low sampled in `IDLE` → `START` and `strt_check_en=1` on the next cycle, with `edge_count=0` in that cycle.
- Frame length from `START` entry to the `data_valid` cycle is `(2 + DATA_BITS + par_en_q) × Prescale_q` cycles. Examples with `Prescale=8`: 80 cycles without parity, 88 with parity.
- `bit_count` values per phase:
  - 0 during `START`, 1..8 during `DATA`.
  - 9 during `PARITY`.
  - 9 during `STOP` without parity, 10 during `STOP` with parity.
- Error flags are examined only on the bit-end cycle of their own phase. A flag that is high at any other time is ignored.
- Changes to `PAR_EN` or `Prescale` mid-frame take effect only at the next `IDLE`→`START` or `DONE`→`START` transition.

## Structure
- Package `uart_rx_pkg` holds:
  - the state enum `uart_rx_state_t` (3-bit encoding);
  - the `DATA_BITS` default;
  - the supported-prescale constants 8, 16, 32.
- Sub-module `uart_rx_edge_bit_counter` provides `edge_count` and `bit_count`:
  - inputs: `clk`, `rst`, `cnt_en`, `cnt_clr`, `Prescale_q`;
  - it owns the wrap logic.
- The FSM itself holds the state register, the `par_en_q` / `Prescale_q` latches and the output decode.

## Test plan
- Good frame, `Prescale=8`, `PAR_EN=0`, data `0xA5`, all error flags 0 → `deser_en` high for 64 cycles; `data_valid` pulses once, 80 cycles after `START` entry.
- Good frame, `Prescale=16`, `PAR_EN=1`, data `0x3C` → `par_check_en` high for 16 cycles with `bit_count=9`; `data_valid` pulses 176 cycles after `START` entry.
- Start glitch: `strt_glitch=1` at start bit end, `Prescale=8` → returns to `IDLE` at cycle 8; `deser_en` never rises; no `data_valid`.
- Parity error with `PAR_EN=1`, and stop error as a separate case → each returns to `IDLE` with counters at 0 and no `data_valid`; a following good frame is received normally.
- Back-to-back frames, `Prescale=32`, `RX_IN` low in the `DONE` cycle → `START` entered directly; two `data_valid` pulses 353 cycles apart (352 frame cycles plus the `DONE` cycle).
- Reset asserted at `edge_count=5` during `DATA`, and `Prescale` changed from 16 to 8 mid-frame → immediate `IDLE` with all outputs 0; the prescale change is not used until the next frame start.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receiver frame sequencer.
// Holds the state encoding, the default frame width and the legal oversampling ratios.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    DONE   = 3'd5
  } uart_rx_state_t;

  localparam int DATA_BITS_DEFAULT = 8;

  localparam logic [5:0] PRESCALE_8  = 6'd8;
  localparam logic [5:0] PRESCALE_16 = 6'd16;
  localparam logic [5:0] PRESCALE_32 = 6'd32;

  // Anything other than a supported ratio runs the frame at x8 oversampling.
  function automatic logic [5:0] legal_prescale(input logic [5:0] prescale);
    case (prescale)
      PRESCALE_8, PRESCALE_16, PRESCALE_32: return prescale;
      default:                              return PRESCALE_8;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_fsm_if.sv
// Line, configuration and checker-flag inputs plus the enables and counters the
// sequencer drives toward the sampler, deserializer and checkers.
interface uart_rx_fsm_if;

  logic       RX_IN;
  logic       PAR_EN;
  logic [5:0] Prescale;
  logic       strt_glitch;
  logic       par_error;
  logic       stop_error;

  logic [4:0] edge_count;
  logic [3:0] bit_count;
  logic       dat_samp_en;
  logic       strt_check_en;
  logic       deser_en;
  logic       par_check_en;
  logic       stop_check_en;
  logic       data_valid;

  modport master (
    output RX_IN, PAR_EN, Prescale, strt_glitch, par_error, stop_error,
    input  edge_count, bit_count, dat_samp_en, strt_check_en, deser_en,
           par_check_en, stop_check_en, data_valid
  );

  modport slave (
    input  RX_IN, PAR_EN, Prescale, strt_glitch, par_error, stop_error,
    output edge_count, bit_count, dat_samp_en, strt_check_en, deser_en,
           par_check_en, stop_check_en, data_valid
  );

endinterface

// File: rtl/uart_rx_edge_bit_counter.sv
// Oversample (edge) and bit counters for one UART frame.
// The edge counter wraps at Prescale_q-1 and carries into the bit counter.
module uart_rx_edge_bit_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       cnt_en,
  input  logic       cnt_clr,
  input  logic [5:0] Prescale_q,
  output logic [4:0] edge_count,
  output logic [3:0] bit_count,
  output logic       bit_end
);

  assign bit_end = ({1'b0, edge_count} == (Prescale_q - 6'd1));

  // NOTE: registers are updated with non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours, matching real hardware.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      edge_count <= '0;
      bit_count  <= '0;
    end else if (cnt_clr) begin
      edge_count <= '0;
      bit_count  <= '0;
    end else if (cnt_en) begin
      if (bit_end) begin
        edge_count <= '0;
        bit_count  <= bit_count + 4'd1;
      end else begin
        edge_count <= edge_count + 5'd1;
      end
    end
  end

endmodule

// File: rtl/uart_rx_fsm.sv
// UART receiver frame sequencer: walks start/data/parity/stop phases, enables the
// matching checker per phase, aborts on checker errors and flags good frames.
module uart_rx_fsm
  import uart_rx_pkg::*;
#(
  parameter int DATA_BITS = DATA_BITS_DEFAULT
) (
  input logic          clk,
  input logic          rst,
  uart_rx_fsm_if.slave bus
);

  uart_rx_state_t state, next_state;
  logic           par_en_q;
  logic [5:0]     Prescale_q;
  logic           cnt_en, cnt_clr, bit_end;
  logic           frame_start;
  logic [4:0]     edge_count;
  logic [3:0]     bit_count;

  uart_rx_edge_bit_counter u_counter (
    .clk        (clk),
    .rst        (rst),
    .cnt_en     (cnt_en),
    .cnt_clr    (cnt_clr),
    .Prescale_q (Prescale_q),
    .edge_count (edge_count),
    .bit_count  (bit_count),
    .bit_end    (bit_end)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  // Configuration is frozen for the whole frame; mid-frame input changes wait for the next start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      par_en_q   <= 1'b0;
      Prescale_q <= PRESCALE_8;
    end else if (frame_start) begin
      par_en_q   <= bus.PAR_EN;
      Prescale_q <= legal_prescale(bus.Prescale);
    end
  end

  // NOTE: every signal written here gets a default first, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    next_state = state;
    cnt_en     = 1'b0;
    cnt_clr    = 1'b0;
    case (state)
      IDLE: begin
        cnt_clr = 1'b1;
        if (!bus.RX_IN) next_state = START;
      end
      START: begin
        cnt_en = 1'b1;
        if (bit_end) next_state = bus.strt_glitch ? IDLE : DATA;
      end
      DATA: begin
        cnt_en = 1'b1;
        if (bit_end && (bit_count == 4'(DATA_BITS)))
          next_state = par_en_q ? PARITY : STOP;
      end
      PARITY: begin
        cnt_en = 1'b1;
        if (bit_end) next_state = bus.par_error ? IDLE : STOP;
      end
      STOP: begin
        cnt_en = 1'b1;
        if (bit_end) next_state = bus.stop_error ? IDLE : DONE;
      end
      DONE: begin
        cnt_clr    = 1'b1;
        next_state = bus.RX_IN ? IDLE : START;
      end
      default: begin
        cnt_clr    = 1'b1;
        next_state = IDLE;
      end
    endcase
    // Aborts and frame completion both leave the counters at zero.
    if (next_state == IDLE || next_state == DONE) cnt_clr = 1'b1;
  end

  assign frame_start = (state == IDLE || state == DONE) && (next_state == START);

  assign bus.edge_count    = edge_count;
  assign bus.bit_count     = bit_count;
  assign bus.dat_samp_en   = (state == START) || (state == DATA) ||
                             (state == PARITY) || (state == STOP);
  assign bus.strt_check_en = (state == START);
  assign bus.deser_en      = (state == DATA);
  assign bus.par_check_en  = (state == PARITY);
  assign bus.stop_check_en = (state == STOP);
  assign bus.data_valid    = (state == DONE);

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Self-checking bench for uart_rx_fsm: a table of directed frames, hand-written
// back-to-back and mid-frame reset sequences, and randomized frames against a phase model.
module tb_uart_rx_fsm;

  localparam int DB = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  uart_rx_fsm_if bus ();

  uart_rx_fsm #(.DATA_BITS(DB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;
  int dv_q[$];

  always @(posedge clk) cyc++;
  always @(negedge clk) if (bus.data_valid === 1'b1) dv_q.push_back(cyc);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // {data_valid, stop_check_en, par_check_en, deser_en, strt_check_en, dat_samp_en, bit_count, edge_count}
  function automatic logic [14:0] observed();
    return {bus.data_valid, bus.stop_check_en, bus.par_check_en, bus.deser_en,
            bus.strt_check_en, bus.dat_samp_en, bus.bit_count, bus.edge_count};
  endfunction

  function automatic int eff_prescale(input int pr);
    return (pr == 8 || pr == 16 || pr == 32) ? pr : 8;
  endfunction

  // Expected outputs k cycles after START entry: each bit lasts P cycles,
  // bit k/P of the frame is start, data 1..DB, optional parity, then stop.
  function automatic logic [14:0] exp_out(input int k, input int P, input bit par);
    int nb, ph;
    logic [14:0] v;
    nb = DB + 2 + int'(par);
    if (k >= nb * P) return 15'h4000;
    ph = k / P;
    v = '0;
    v[4:0] = 5'(k % P);
    v[8:5] = 4'(ph);
    v[9]   = 1'b1;
    v[10]  = (ph == 0);
    v[11]  = (ph >= 1 && ph <= DB);
    v[12]  = par && (ph == DB + 1);
    v[13]  = (ph == nb - 1);
    return v;
  endfunction

  // err: 0 start glitch, 1 parity error, 2 stop error, anything else none.
  task automatic frame(input int pr, input bit par, input int err, input bit from_done,
                       input bit chain, input int pr2, input bit par2,
                       output int lat, output int n_deser, output int n_par, output int n_dv);
    int P, nb, ab, total, ph;
    bit be;
    P  = eff_prescale(pr);
    nb = DB + 2 + int'(par);
    ab = (err == 0) ? 0 : (err == 1 && par) ? DB + 1 : (err == 2) ? nb - 1 : -1;
    total = (ab >= 0) ? (ab + 1) * P : nb * P + 1;
    lat = -1; n_deser = 0; n_par = 0; n_dv = 0;
    if (!from_done) begin
      @(negedge clk);
      check("idle", 32'(observed()), 32'h0);
      bus.RX_IN = 1'b0; bus.Prescale = 6'(pr); bus.PAR_EN = par;
      bus.strt_glitch = 1'b0; bus.par_error = 1'b0; bus.stop_error = 1'b0;
    end
    for (int k = 0; k < total; k++) begin
      @(negedge clk);
      check("frame", 32'(observed()), 32'(exp_out(k, P, par)));
      if (bus.deser_en === 1'b1) n_deser++;
      if (bus.par_check_en === 1'b1) n_par++;
      if (bus.data_valid === 1'b1) begin n_dv++; lat = k; end
      ph = k / P;
      be = (k < nb * P) && (k % P == P - 1);
      bus.RX_IN    = 1'($urandom);
      bus.Prescale = 6'($urandom_range(0, 63));
      bus.PAR_EN   = 1'($urandom);
      bus.strt_glitch = (be && ph == 0)               ? (err == 0) : 1'($urandom);
      bus.par_error   = (be && par && ph == DB + 1)   ? (err == 1) : 1'($urandom);
      bus.stop_error  = (be && ph == nb - 1)          ? (err == 2) : 1'($urandom);
      if (k == total - 1) begin
        bus.RX_IN = !chain;
        if (chain) begin bus.Prescale = 6'(pr2); bus.PAR_EN = par2; end
      end
    end
    if (!chain) begin
      @(negedge clk);
      check("post_idle", 32'(observed()), 32'h0);
      bus.strt_glitch = 1'b0; bus.par_error = 1'b0; bus.stop_error = 1'b0;
    end
  endtask

  typedef struct {
    int pr; bit par; int err;
    int lat; int n_deser; int n_par; int n_dv;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int lat, nd, np, ndv, sz, pr, err;
    bit par;

    tbl[0] = '{pr: 8,  par: 0, err: -1, lat: 80,  n_deser: 64,  n_par: 0,  n_dv: 1};
    tbl[1] = '{pr: 16, par: 1, err: -1, lat: 176, n_deser: 128, n_par: 16, n_dv: 1};
    tbl[2] = '{pr: 8,  par: 0, err: 0,  lat: -1,  n_deser: 0,   n_par: 0,  n_dv: 0};
    tbl[3] = '{pr: 8,  par: 1, err: 1,  lat: -1,  n_deser: 64,  n_par: 8,  n_dv: 0};
    tbl[4] = '{pr: 16, par: 0, err: 2,  lat: -1,  n_deser: 128, n_par: 0,  n_dv: 0};
    tbl[5] = '{pr: 8,  par: 0, err: -1, lat: 80,  n_deser: 64,  n_par: 0,  n_dv: 1};
    tbl[6] = '{pr: 5,  par: 0, err: -1, lat: 80,  n_deser: 64,  n_par: 0,  n_dv: 1};
    tbl[7] = '{pr: 32, par: 1, err: -1, lat: 352, n_deser: 256, n_par: 32, n_dv: 1};

    bus.RX_IN = 1'b1; bus.PAR_EN = 1'b0; bus.Prescale = 6'd8;
    bus.strt_glitch = 1'b0; bus.par_error = 1'b0; bus.stop_error = 1'b0;

    #12;
    check("reset_outputs", 32'(observed()), 32'h0);
    @(negedge clk); rst = 1'b1;

    for (int i = 0; i < 8; i++) begin
      frame(tbl[i].pr, tbl[i].par, tbl[i].err, 1'b0, 1'b0, 0, 1'b0, lat, nd, np, ndv);
      check($sformatf("tbl%0d_latency", i), 32'(lat), 32'(tbl[i].lat));
      check($sformatf("tbl%0d_deser_cycles", i), 32'(nd), 32'(tbl[i].n_deser));
      check($sformatf("tbl%0d_par_cycles", i), 32'(np), 32'(tbl[i].n_par));
      check($sformatf("tbl%0d_dv_count", i), 32'(ndv), 32'(tbl[i].n_dv));
    end

    // Back-to-back frames at x32 with parity: line already low in the DONE cycle.
    sz = dv_q.size();
    frame(32, 1'b1, -1, 1'b0, 1'b1, 32, 1'b1, lat, nd, np, ndv);
    frame(32, 1'b1, -1, 1'b1, 1'b0, 0, 1'b0, lat, nd, np, ndv);
    check("b2b_dv_count", 32'(dv_q.size() - sz), 32'd2);
    if (dv_q.size() - sz == 2)
      check("b2b_dv_spacing", 32'(dv_q[sz + 1] - dv_q[sz]), 32'd353);

    // Mid-frame reset at edge_count=5 of data bit 1, after Prescale changed 16 -> 8.
    sz = dv_q.size();
    @(negedge clk);
    bus.RX_IN = 1'b0; bus.Prescale = 6'd16; bus.PAR_EN = 1'b0;
    for (int k = 0; k < 22; k++) begin
      @(negedge clk);
      check("pre_reset", 32'(observed()), 32'(exp_out(k, 16, 1'b0)));
      bus.RX_IN       = 1'($urandom);
      bus.strt_glitch = (k == 15) ? 1'b0 : 1'($urandom);
      bus.par_error   = 1'($urandom);
      bus.stop_error  = 1'($urandom);
      if (k >= 10) bus.Prescale = 6'd8;
    end
    rst = 1'b0;
    #1;
    check("reset_async", 32'(observed()), 32'h0);
    @(negedge clk);
    bus.RX_IN = 1'b1; bus.strt_glitch = 1'b0; bus.par_error = 1'b0; bus.stop_error = 1'b0;
    check("reset_hold", 32'(observed()), 32'h0);
    rst = 1'b1;
    check("reset_no_dv", 32'(dv_q.size() - sz), 32'd0);
    frame(8, 1'b0, -1, 1'b0, 1'b0, 0, 1'b0, lat, nd, np, ndv);
    check("after_reset_latency", 32'(lat), 32'd80);

    // Randomized frames: configuration, error injection and flag noise.
    for (int i = 0; i < 12; i++) begin
      case ($urandom % 4)
        0:       pr = 8;
        1:       pr = 16;
        2:       pr = 32;
        default: pr = int'($urandom_range(0, 63));
      endcase
      par = 1'($urandom);
      err = int'($urandom % 5) - 1;
      frame(pr, par, err, 1'b0, 1'b0, 0, 1'b0, lat, nd, np, ndv);
      check($sformatf("rand%0d_dv_count", i), 32'(ndv),
            (err == 0 || (err == 1 && par) || err == 2) ? 32'd0 : 32'd1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
